// File: rtl/ffxkpipe_pkg.sv
// Shared types and helpers for the ffxkpipe reconfigurable delay pipeline.
package ffxkpipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    function automatic int dly_w(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    // Requested delays outside 1..maxk saturate to the nearest legal tap.
    function automatic int clamp_dly(input int d, input int maxk);
        if (d < 1) return 1;
        if (d > maxk) return maxk;
        return d;
    endfunction

endpackage

// File: rtl/ffxkpipe_stage.sv
// One pipeline stage: WIDTH-bit data plus a valid bit that can be cleared
// independently of the advance enable.
module ffxkpipe_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_dat,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q_dat,
    output logic             q_vld
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             vld_q, vld_d;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (en) begin
            dat_d = d_dat;
            vld_d = d_vld;
        end
        if (clr) vld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign q_dat = dat_q;
    assign q_vld = vld_q;

endmodule

// File: rtl/ffxkpipe.sv
// Runtime-reconfigurable delay pipeline with valid tracking, stall, flush and
// a drain-then-load handshake for changing the active tap.
module ffxkpipe
    import ffxkpipe_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAXK    = 8,
    parameter int DEF_DLY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       ivld,
    input  logic [WIDTH-1:0]           idat,
    output logic                       irdy,
    output logic [WIDTH-1:0]           odat,
    output logic                       ovld,
    input  logic                       cfg_req,
    input  logic [dly_w(MAXK)-1:0]     cfg_dly,
    output logic                       cfg_ack,
    output logic [dly_w(MAXK)-1:0]     dly,
    output logic [dly_w(MAXK)-1:0]     cnt
);

    localparam int DW = dly_w(MAXK);

    state_e                    state_q;
    logic [DW-1:0]             dly_q;
    logic                      cfg_ack_q;
    logic [DW-1:0]             cnt_q, cnt_d;
    logic [MAXK-1:0][WIDTH-1:0] s_dat;
    logic [MAXK-1:0]           s_vld;
    logic                      acc;
    logic                      v_clr;

    assign irdy  = (state_q == ST_RUN);
    assign acc   = ivld & irdy;
    // LOAD wipes every valid so nothing from the old geometry leaks out.
    assign v_clr = flush | (state_q == ST_LOAD);

    for (genvar gi = 0; gi < MAXK; gi++) begin : g_stg
        logic [WIDTH-1:0] d_dat;
        logic             d_vld;
        if (gi == 0) begin : g_head
            assign d_dat = idat;
            assign d_vld = acc;
        end else begin : g_body
            assign d_dat = s_dat[gi-1];
            assign d_vld = s_vld[gi-1];
        end
        ffxkpipe_stage #(.WIDTH(WIDTH)) u_stg (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .clr   (v_clr),
            .d_dat (d_dat),
            .d_vld (d_vld),
            .q_dat (s_dat[gi]),
            .q_vld (s_vld[gi])
        );
    end

    always_comb begin
        odat = '0;
        ovld = 1'b0;
        for (int i = 0; i < MAXK; i++) begin
            if (dly_q == DW'(i + 1)) begin
                odat = s_dat[i];
                ovld = s_vld[i];
            end
        end
    end

    // Occupancy of the active window only; stages past the tap are ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (v_clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (acc && !ovld)      cnt_d = cnt_q + DW'(1);
            else if (!acc && ovld) cnt_d = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            dly_q     <= DW'(DEF_DLY);
            cfg_ack_q <= 1'b0;
        end else begin
            cfg_ack_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (en && cfg_req) state_q <= ST_DRAIN;
                end
                // Exit does not wait on en, so a flushed pipe leaves promptly.
                ST_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q   <= ST_LOAD;
                        cfg_ack_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    dly_q   <= DW'(clamp_dly(int'(cfg_dly), MAXK));
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign cfg_ack = cfg_ack_q;
    assign dly     = dly_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_ffxkpipe.sv
// Directed bench for ffxkpipe: latency, stall, reconfig, clamp, flush, async reset.
module tb_ffxkpipe;

    localparam int WIDTH = 16;
    localparam int MAXK  = 8;
    localparam int DW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic             ivld;
    logic [WIDTH-1:0] idat;
    logic             irdy;
    logic [WIDTH-1:0] odat;
    logic             ovld;
    logic             cfg_req;
    logic [DW-1:0]    cfg_dly;
    logic             cfg_ack;
    logic [DW-1:0]    dly;
    logic [DW-1:0]    cnt;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ffxkpipe #(.WIDTH(WIDTH), .MAXK(MAXK), .DEF_DLY(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .ivld    (ivld),
        .idat    (idat),
        .irdy    (irdy),
        .odat    (odat),
        .ovld    (ovld),
        .cfg_req (cfg_req),
        .cfg_dly (cfg_dly),
        .cfg_ack (cfg_ack),
        .dly     (dly),
        .cnt     (cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; ivld = 1'b0; idat = '0;
        cfg_req = 1'b0; cfg_dly = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovld", 32'(ovld), 0);
        check("rst_odat", 32'(odat), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_dly", 32'(dly), 3);
        check("rst_irdy", 32'(irdy), 1);
        check("rst_ack", 32'(cfg_ack), 0);
        rst = 1'b0;

        // Default delay 3, streaming
        en = 1'b1; ivld = 1'b1; idat = 16'h00A5; tick();
        check("s_cnt1", 32'(cnt), 1);
        check("s_ovld1", 32'(ovld), 0);
        idat = 16'h00B1; tick();
        check("s_cnt2", 32'(cnt), 2);
        idat = 16'h00B2; tick();
        check("s_ovld3", 32'(ovld), 1);
        check("s_odat3", 32'(odat), 32'h00A5);
        check("s_cnt3", 32'(cnt), 3);
        idat = 16'h00B3; tick();
        check("s_odat4", 32'(odat), 32'h00B1);
        check("s_cnt4", 32'(cnt), 3);
        ivld = 1'b0; tick();
        check("s_odat5", 32'(odat), 32'h00B2);
        check("s_cnt5", 32'(cnt), 2);
        tick();
        check("s_odat6", 32'(odat), 32'h00B3);
        check("s_cnt6", 32'(cnt), 1);
        tick();
        check("s_ovld7", 32'(ovld), 0);
        check("s_cnt7", 32'(cnt), 0);

        // Stall with valid output at the tap
        ivld = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            idat = 16'(k); tick();
        end
        check("st_pre", 32'(odat), 1);
        en = 1'b0; idat = 16'd4;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("st_hold_odat", 32'(odat), 1);
            check("st_hold_ovld", 32'(ovld), 1);
            check("st_hold_cnt", 32'(cnt), 3);
        end
        en = 1'b1; tick();
        check("st_o2", 32'(odat), 2);
        ivld = 1'b0; tick();
        check("st_o3", 32'(odat), 3);
        tick();
        check("st_o4", 32'(odat), 4);
        check("st_o4v", 32'(ovld), 1);
        tick();
        check("st_end", 32'(ovld), 0);

        // Reconfig to 6 with 4 beats in flight
        ivld = 1'b1;
        idat = 16'h0021; tick();
        idat = 16'h0022; tick();
        idat = 16'h0023; tick();
        check("rc_tap21", 32'(odat), 32'h0021);
        idat = 16'h0024; cfg_req = 1'b1; cfg_dly = 4'd6; tick();
        check("rc_irdy", 32'(irdy), 0);
        check("rc_tap22", 32'(odat), 32'h0022);
        check("rc_cnt3", 32'(cnt), 3);
        idat = 16'h0099;
        tick();
        check("rc_tap23", 32'(odat), 32'h0023);
        check("rc_cnt2", 32'(cnt), 2);
        tick();
        check("rc_tap24", 32'(odat), 32'h0024);
        check("rc_cnt1", 32'(cnt), 1);
        tick();
        check("rc_empty", 32'(ovld), 0);
        check("rc_cnt0", 32'(cnt), 0);
        check("rc_noack", 32'(cfg_ack), 0);
        tick();
        check("rc_ack", 32'(cfg_ack), 1);
        check("rc_dly_old", 32'(dly), 3);
        cfg_req = 1'b0; ivld = 1'b0; tick();
        check("rc_ack_pulse", 32'(cfg_ack), 0);
        check("rc_dly6", 32'(dly), 6);
        check("rc_irdy1", 32'(irdy), 1);
        check("rc_nostale", 32'(ovld), 0);
        ivld = 1'b1; idat = 16'h005A; tick();
        ivld = 1'b0;
        check("rc_lat1", 32'(ovld), 0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            check("rc_lat", 32'(ovld), (k == 6) ? 32'd1 : 32'd0);
        end
        check("rc_odat6", 32'(odat), 32'h005A);
        tick();
        check("rc_after", 32'(ovld), 0);

        // Clamp low: 0 -> 1, two cycles request to ack
        cfg_req = 1'b1; cfg_dly = 4'd0; tick();
        check("cl0_drain", 32'(cfg_ack), 0);
        tick();
        check("cl0_ack", 32'(cfg_ack), 1);
        cfg_req = 1'b0; tick();
        check("cl0_dly", 32'(dly), 1);
        ivld = 1'b1; idat = 16'h0077; tick();
        check("cl0_lat", 32'(ovld), 1);
        check("cl0_odat", 32'(odat), 32'h0077);
        ivld = 1'b0; tick();
        check("cl0_gone", 32'(ovld), 0);

        // Clamp high: 15 -> 8
        cfg_req = 1'b1; cfg_dly = 4'd15; tick();
        tick();
        check("cl15_ack", 32'(cfg_ack), 1);
        cfg_req = 1'b0; tick();
        check("cl15_dly", 32'(dly), 8);

        // Flush during DRAIN with cnt=2
        ivld = 1'b1; idat = 16'h0031; tick();
        idat = 16'h0032; cfg_req = 1'b1; cfg_dly = 4'd5; tick();
        check("fl_cnt2", 32'(cnt), 2);
        check("fl_irdy", 32'(irdy), 0);
        ivld = 1'b0; flush = 1'b1; tick();
        check("fl_cnt0", 32'(cnt), 0);
        check("fl_noack", 32'(cfg_ack), 0);
        check("fl_ovld_a", 32'(ovld), 0);
        flush = 1'b0; tick();
        check("fl_load", 32'(cfg_ack), 1);
        check("fl_ovld_b", 32'(ovld), 0);
        cfg_req = 1'b0; tick();
        check("fl_dly5", 32'(dly), 5);
        check("fl_ovld_c", 32'(ovld), 0);

        // Async reset mid-DRAIN
        ivld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idat = 16'(16'h0041 + k); tick();
        end
        check("ar_odat41", 32'(odat), 32'h0041);
        check("ar_cnt5", 32'(cnt), 5);
        idat = 16'h0046; cfg_req = 1'b1; cfg_dly = 4'd2; tick();
        check("ar_drain", 32'(irdy), 0);
        #3 rst = 1'b1;
        #1;
        check("ar_ovld", 32'(ovld), 0);
        check("ar_odat", 32'(odat), 0);
        check("ar_cnt", 32'(cnt), 0);
        check("ar_dly", 32'(dly), 3);
        check("ar_irdy", 32'(irdy), 1);
        cfg_req = 1'b0; ivld = 1'b0;
        #2 rst = 1'b0;
        tick();
        check("ar_noack", 32'(cfg_ack), 0);
        check("ar_dly_hold", 32'(dly), 3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
